// File: rtl/ps2_rx_fifo.sv
// ============================================================================
//  Module   : ps2_rx_fifo
//  Brief    : PS/2 device-to-host receiver with scan-code FIFO.
//             Optional idle timeout enabled by defining PS2_RX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       ready,
    input  logic       nextdata_n,
    output logic       overflow
);

    localparam int             c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]     c_ST_START  = 4'd0;
    localparam logic [3:0]     c_ST_FIRST  = 4'd1;
    localparam logic [3:0]     c_ST_LAST   = 4'd8;
    localparam logic [3:0]     c_ST_PARITY = 4'd9;
    localparam logic [3:0]     c_ST_STOP   = 4'd10;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2))
    begin : g_bad_params
        $error("ps2_rx_fifo: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
    end

    // ------------------------------------------------------------------
    // Synchronizers and falling-edge detect (bus idles high)
    // ------------------------------------------------------------------
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    logic       w_fall;
    logic       w_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_bit  = r_data_sync[1];

    // ------------------------------------------------------------------
    // Deframer: r_cnt is the frame position (0 = waiting for start bit)
    // ------------------------------------------------------------------
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic [7:0] r_shift;
    logic       r_parity;
    logic       w_shift_en;
    logic       w_parity_en;
    logic       w_push;
    logic [2:0] w_bit_idx;
    logic       w_timeout;

`ifdef PS2_RX_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] r_idle;

    assign w_timeout = (r_cnt != c_ST_START) && (r_idle == c_TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_idle <= '0;
        end else if (w_fall || (r_cnt == c_ST_START) || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + c_TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= c_ST_START;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Next-state logic; a high start bit is treated as a glitch
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_fall) begin
            if (r_cnt == c_ST_START) begin
                if (!w_bit) begin
                    w_cnt_next = c_ST_FIRST;
                end
            end else if (r_cnt == c_ST_STOP) begin
                w_cnt_next = c_ST_START;
            end else begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end else if (w_timeout) begin
            w_cnt_next = c_ST_START;
        end
    end

    // Output decode for the current frame position
    always_comb begin
        w_shift_en  = 1'b0;
        w_parity_en = 1'b0;
        w_push      = 1'b0;
        w_bit_idx   = r_cnt[2:0] - 3'd1;
        if (w_fall) begin
            w_shift_en  = (r_cnt >= c_ST_FIRST) && (r_cnt <= c_ST_LAST);
            w_parity_en = (r_cnt == c_ST_PARITY);
            w_push      = (r_cnt == c_ST_STOP) && w_bit && (^{r_shift, r_parity});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            if (w_shift_en) begin
                r_shift[w_bit_idx] <= w_bit;
            end
            if (w_parity_en) begin
                r_parity <= w_bit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;

    assign w_full    = (r_count == c_FULL);
    assign w_pop     = ~nextdata_n && (r_count != '0);
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack
    assign w_push_ok = w_push && (~w_full || w_pop);
    assign w_drop    = w_push && w_full && ~w_pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_pop) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign data     = r_mem[r_rd_ptr];
    assign ready    = (r_count != '0);
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// ============================================================================
//  Module   : tb_ps2_rx_fifo
//  Brief    : Scoreboard bench for ps2_rx_fifo; popped bytes are checked
//             against a queue of expected scan codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] r_exp;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data       (data),
        .ready      (ready),
        .nextdata_n (nextdata_n),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Monitor: every accepted pop must match the head of the expected queue
    always @(negedge clock) begin
        if (!reset && ready && !nextdata_n) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected got=%02h want=<none>", data);
            end else begin
                r_exp = exp_q.pop_front();
                if (data !== r_exp) begin
                    n_err++;
                    $display("FAIL pop_data got=%02h want=%02h", data, r_exp);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(5);
        ps2_clk = 1'b0;
        tick(5);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic par_flip,
                                          input logic stop_bit);
        return {stop_bit, (~(^b)) ^ par_flip, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
        logic [10:0] f;
        f = frame(b, par_flip, stop_bit);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    endtask

    task automatic pop();
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
    endtask

    initial begin
        logic [10:0] f;
        tick(3);
        check("reset_ready", int'(ready), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_data", int'(data), 8'h00);
        reset = 1'b0;
        tick(2);

        // 0x1C visible within 4 clocks of the stop-bit fall
        f = frame(8'h1C, 1'b0, 1'b1);
        exp_q.push_back(8'h1C);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(5);
        ps2_clk = 1'b0;
        tick(4);
        check("t1_ready", int'(ready), 1);
        check("t1_data", int'(data), 8'h1C);
        tick(1);
        ps2_clk = 1'b1;
        tick(5);
        pop();
        check("t1_ready_after_pop", int'(ready), 0);

        // Bad parity and bad stop are discarded
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t2_badpar_ready", int'(ready), 0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t2_badstop_ready", int'(ready), 0);
        check("t2_overflow", int'(overflow), 0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1);
        check("t2_f0_data", int'(data), 8'hF0);
        pop();

        // Nine frames into an 8-deep FIFO
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) exp_q.push_back(8'(k));
            send_frame(8'(k), 1'b0, 1'b1);
        end
        check("t3_overflow_set", int'(overflow), 1);
        check("t3_head", int'(data), 8'h01);
        pop();
        check("t3_overflow_clr", int'(overflow), 0);
        for (int k = 0; k < 7; k++) pop();
        check("t3_empty", int'(ready), 0);

        // Full FIFO: pop coincides with evaluation of 0x2A stop bit
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(8'h11 + 8'(k));
            send_frame(8'h11 + 8'(k), 1'b0, 1'b1);
        end
        exp_q.push_back(8'h2A);
        f = frame(8'h2A, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(5);
        ps2_clk = 1'b0;
        tick(2);
        nextdata_n = 1'b0;
        tick(1);
        nextdata_n = 1'b1;
        check("t4_overflow", int'(overflow), 0);
        tick(2);
        ps2_clk = 1'b1;
        tick(5);
        check("t4_overflow_late", int'(overflow), 0);
        for (int k = 0; k < 7; k++) pop();
        check("t4_count8_ready", int'(ready), 1);
        check("t4_last", int'(data), 8'h2A);
        pop();
        check("t4_empty", int'(ready), 0);

        // Reset mid-frame
        f = frame(8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("t5_reset_ready", int'(ready), 0);
        tick(2);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1);
        check("t5_ready", int'(ready), 1);
        check("t5_data", int'(data), 8'h55);
        pop();
        check("t5_empty", int'(ready), 0);

        // Partial frame, long idle, then 0x33
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        tick(100);
`ifdef PS2_RX_TIMEOUT_EN
        exp_q.push_back(8'h33);
`else
        exp_q.push_back(8'h30);
`endif
        send_frame(8'h33, 1'b0, 1'b1);
        check("t6_ready", int'(ready), 1);
        pop();
        check("t6_empty", int'(ready), 0);

        tick(5);
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
